// File: rtl/mersenne_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mersenne_pkg
//  Description : Shared types and constants for the Mersenne trial-factoring
//                sequencer (state encoding, default widths, divider width).
//  Revision    : 1.0 - initial release
// ============================================================================
package mersenne_pkg;

    localparam int EXP_W_DEFAULT = 32;
    localparam int Q_W_DEFAULT   = 16;
    localparam int DIV_W         = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_SQ    = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_DBL   = 3'd5,
        S_DONE  = 3'd6
    } drv_state_t;

endpackage
`default_nettype wire

// File: rtl/mersenne_trial_driver_mod_double.sv
`default_nettype none
// ============================================================================
//  Module      : mod_double
//  Description : Combinational modular doubling: (2r >= q) ? 2r - q : 2r.
//                Assumes r < q, so a single conditional subtract suffices.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_double #(
    parameter int Q_W = 16
) (
    input  logic [Q_W-1:0] i_r,
    input  logic [Q_W-1:0] i_q,
    output logic [Q_W-1:0] o_dbl
);

    logic [Q_W:0] w_t;
    logic [Q_W:0] w_q_ext;
    logic [Q_W:0] w_diff;

    // Doubling needs one extra bit so 2r never wraps before the compare
    always_comb begin
        w_t     = {i_r, 1'b0};
        w_q_ext = {1'b0, i_q};
        w_diff  = w_t - w_q_ext;
        o_dbl   = (w_t >= w_q_ext) ? w_diff[Q_W-1:0] : w_t[Q_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/mersenne_trial_driver.sv
`default_nettype none
// ============================================================================
//  Module      : mersenne_trial_driver
//  Description : Computes 2^p mod q by left-to-right square-and-double,
//                issuing each squaring reduction to the external divider over
//                its start/finished handshake. Reports whether q | 2^p - 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module mersenne_trial_driver
    import mersenne_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEFAULT,
    parameter int Q_W   = Q_W_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [EXP_W-1:0] cmd_exp,
    input  logic [Q_W-1:0]   cmd_q,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_divides,
    output logic [Q_W-1:0]   res_residue,
    output logic             res_err,
    output logic             div_start,
    output logic [DIV_W-1:0] div_numerator,
    output logic [DIV_W-1:0] div_denominator,
    input  logic [DIV_W-1:0] div_remainder,
    input  logic             div_finished
);

    localparam int             c_CNT_W    = $clog2(EXP_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(EXP_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [Q_W-1:0] c_ONE      = Q_W'(1);
    localparam logic [Q_W-1:0] c_TWO      = Q_W'(2);

    drv_state_t          r_state;
    logic [EXP_W-1:0]    r_e;
    logic [Q_W-1:0]      r_q;
    logic [Q_W-1:0]      r_r;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_wait_first;
    logic                r_res_valid;
    logic                r_res_divides;
    logic [Q_W-1:0]      r_res_residue;
    logic                r_res_err;
    logic                r_div_start;
    logic [DIV_W-1:0]    r_div_num;
    logic [DIV_W-1:0]    r_div_den;

    logic [Q_W-1:0]      w_dbl;
    logic [Q_W-1:0]      w_r_next;
    logic [DIV_W-1:0]    w_r_ext;
    logic [DIV_W-1:0]    w_q_ext;

    mod_double #(
        .Q_W   (Q_W)
    ) u_mod_double (
        .i_r   (r_r),
        .i_q   (r_q),
        .o_dbl (w_dbl)
    );

    // Residue after the current S_DBL step, and zero-extended divider operands
    always_comb begin
        w_r_next = r_e[EXP_W-1] ? w_dbl : r_r;
        w_r_ext  = {{(DIV_W-Q_W){1'b0}}, r_r};
        w_q_ext  = {{(DIV_W-Q_W){1'b0}}, r_q};
    end

    // Reset is folded in so no command can be taken while reset is asserted
    assign cmd_ready       = (r_state == S_IDLE) && !sys_rst;
    assign res_valid       = r_res_valid;
    assign res_divides     = r_res_divides;
    assign res_residue     = r_res_residue;
    assign res_err         = r_res_err;
    assign div_start       = r_div_start;
    assign div_numerator   = r_div_num;
    assign div_denominator = r_div_den;

    // Main sequencer: exponent scan, square via divider, conditional double
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_e           <= '0;
            r_q           <= '0;
            r_r           <= '0;
            r_cnt         <= '0;
            r_wait_first  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_divides <= 1'b0;
            r_res_residue <= '0;
            r_res_err     <= 1'b0;
            r_div_start   <= 1'b0;
            r_div_num     <= '0;
            r_div_den     <= '0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_e   <= cmd_exp;
                        r_q   <= cmd_q;
                        r_r   <= c_ONE;
                        r_cnt <= c_CNT_INIT;
                        if (cmd_q < c_TWO) begin
                            r_res_err     <= 1'b1;
                            r_res_residue <= '0;
                            r_res_divides <= 1'b0;
                            r_res_valid   <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_cnt == '0) begin
                        // p == 0 lands here with r still 1
                        r_res_err     <= 1'b0;
                        r_res_residue <= r_r;
                        r_res_divides <= (r_r == c_ONE);
                        r_res_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end else if (!r_e[EXP_W-1]) begin
                        r_e   <= {r_e[EXP_W-2:0], 1'b0};
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_state <= S_SQ;
                    end
                end
                S_SQ: begin
                    r_div_num   <= w_r_ext * w_r_ext;
                    r_div_den   <= w_q_ext;
                    r_div_start <= 1'b1;
                    r_state     <= S_START;
                end
                S_START: begin
                    r_wait_first <= 1'b1;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // A finished level left over from the last reduction is
                    // not trusted on the first cycle after the start pulse
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (div_finished) begin
                        r_r     <= div_remainder[Q_W-1:0];
                        r_state <= S_DBL;
                    end
                end
                S_DBL: begin
                    r_r   <= w_r_next;
                    r_e   <= {r_e[EXP_W-2:0], 1'b0};
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_res_err     <= 1'b0;
                        r_res_residue <= w_r_next;
                        r_res_divides <= (w_r_next == c_ONE);
                        r_res_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_state <= S_SQ;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mersenne_trial_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mersenne_trial_driver
//  Description : Directed self-checking bench for mersenne_trial_driver with a
//                behavioural divider (random 2-40 cycle latency, level finish).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mersenne_trial_driver;

    localparam int EXP_W = 32;
    localparam int Q_W   = 16;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [EXP_W-1:0] cmd_exp = '0;
    logic [Q_W-1:0]   cmd_q = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             res_divides;
    logic [Q_W-1:0]   res_residue;
    logic             res_err;
    logic             div_start;
    logic [31:0]      div_numerator;
    logic [31:0]      div_denominator;
    logic [31:0]      div_remainder;
    logic             div_finished;

    int n_checks = 0;
    int n_fail   = 0;

    mersenne_trial_driver #(
        .EXP_W (EXP_W),
        .Q_W   (Q_W)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_exp         (cmd_exp),
        .cmd_q           (cmd_q),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_divides     (res_divides),
        .res_residue     (res_residue),
        .res_err         (res_err),
        .div_start       (div_start),
        .div_numerator   (div_numerator),
        .div_denominator (div_denominator),
        .div_remainder   (div_remainder),
        .div_finished    (div_finished)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural divider: level finish held until the next start
    logic        stuck = 1'b0;
    logic        m_fin;
    logic [31:0] m_rem;
    logic [31:0] m_num;
    logic [31:0] m_den;
    int          m_cnt;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_fin <= 1'b0;
            m_rem <= '0;
            m_num <= '0;
            m_den <= 32'd1;
            m_cnt <= 0;
        end else if (div_start) begin
            m_num <= div_numerator;
            m_den <= div_denominator;
            if (stuck) begin
                m_rem <= div_numerator % div_denominator;
                m_fin <= 1'b1;
                m_cnt <= 0;
            end else begin
                m_fin <= 1'b0;
                m_cnt <= int'($urandom_range(40, 2)) - 1;
            end
        end else begin
            if (stuck) m_fin <= 1'b1;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_fin <= 1'b1;
                    m_rem <= m_num % m_den;
                end
            end
        end
    end

    assign div_finished  = m_fin;
    assign div_remainder = m_rem;

    // Count start pulses and back-to-back (illegal) start cycles
    int   start_count = 0;
    int   dbl_count   = 0;
    logic prev_start  = 1'b0;

    always @(posedge sys_clk) begin
        if (!sys_rst && div_start) begin
            start_count = start_count + 1;
            if (prev_start) dbl_count = dbl_count + 1;
        end
        prev_start = div_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [EXP_W-1:0] p, input logic [Q_W-1:0] q);
        @(negedge sys_clk);
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_exp   = p;
        cmd_q     = q;
        cmd_valid = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic run_case(input string tag, input logic [EXP_W-1:0] p, input logic [Q_W-1:0] q,
                            input logic [Q_W-1:0] exp_res, input logic exp_div, input logic exp_err,
                            input int exp_starts, input int hold);
        int s0;
        int d0;
        s0 = start_count;
        d0 = dbl_count;
        issue(p, q);
        wait_result(tag);
        check({tag, "_residue"}, 32'(res_residue), 32'(exp_res));
        check({tag, "_divides"}, 32'(res_divides), 32'(exp_div));
        check({tag, "_err"},     32'(res_err),     32'(exp_err));
        check({tag, "_starts"},  32'(start_count - s0), 32'(exp_starts));
        check({tag, "_dblstart"}, 32'(dbl_count - d0), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge sys_clk);
            check({tag, "_hold_valid"},   32'(res_valid),   32'd1);
            check({tag, "_hold_ready"},   32'(cmd_ready),   32'd0);
            check({tag, "_hold_residue"}, 32'(res_residue), 32'(exp_res));
        end
        res_ready = 1'b1;
        @(negedge sys_clk);
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        check({tag, "_b2b_ready"},  32'(cmd_ready), 32'd1);
        check({tag, "_residue_kept"}, 32'(res_residue), 32'(exp_res));
    endtask

    initial begin
        int s0;
        bit seen;
        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_cmd_ready", 32'(cmd_ready),   32'd0);
        check("rst_res_valid", 32'(res_valid),   32'd0);
        check("rst_residue",   32'(res_residue), 32'd0);
        check("rst_divides",   32'(res_divides), 32'd0);
        check("rst_err",       32'(res_err),     32'd0);
        check("rst_div_start", 32'(div_start),   32'd0);
        check("rst_div_num",   div_numerator,    32'd0);
        check("rst_div_den",   div_denominator,  32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Directed cases with hand-computed results
        run_case("p11_q23", 32'd11, 16'd23, 16'd1, 1'b1, 1'b0, 4, 0);
        run_case("p11_q13", 32'd11, 16'd13, 16'd7, 1'b0, 1'b0, 4, 0);
        run_case("p23_q47", 32'd23, 16'd47, 16'd1, 1'b1, 1'b0, 5, 0);
        run_case("p0_q5",   32'd0,  16'd5,  16'd1, 1'b1, 1'b0, 0, 0);
        run_case("q0",      32'd11, 16'd0,  16'd0, 1'b0, 1'b1, 0, 0);
        run_case("q1",      32'd11, 16'd1,  16'd0, 1'b0, 1'b1, 0, 0);
        run_case("p5_q2",   32'd5,  16'd2,  16'd0, 1'b0, 1'b0, 3, 0);

        // Reset during the first S_WAIT cycle of p=23, q=47
        issue(32'd23, 16'd47);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (div_start) begin
                seen = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check("midrst_start_seen", 32'(seen), 32'd1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_cmd_ready", 32'(cmd_ready),   32'd0);
        check("midrst_res_valid", 32'(res_valid),   32'd0);
        check("midrst_residue",   32'(res_residue), 32'd0);
        check("midrst_err",       32'(res_err),     32'd0);
        check("midrst_divides",   32'(res_divides), 32'd0);
        check("midrst_div_start", 32'(div_start),   32'd0);
        check("midrst_div_num",   div_numerator,    32'd0);
        check("midrst_div_den",   div_denominator,  32'd0);
        sys_rst = 1'b0;
        s0 = start_count;
        @(negedge sys_clk);
        check("midrst_ready_after", 32'(cmd_ready), 32'd1);
        repeat (50) @(negedge sys_clk);
        check("midrst_no_start", 32'(start_count - s0), 32'd0);
        check("midrst_idle_valid", 32'(res_valid), 32'd0);

        // Divider finished stuck high across commands, plus result hold
        stuck = 1'b1;
        repeat (3) @(negedge sys_clk);
        run_case("stuck_p23_q47", 32'd23, 16'd47, 16'd1, 1'b1, 1'b0, 5, 10);
        run_case("stuck_p11_q13", 32'd11, 16'd13, 16'd7, 1'b0, 1'b0, 4, 0);
        stuck = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mersenne_trial_driver.md
# mersenne_trial_driver

Initiator-side sequencer for the trial-factoring datapath. It accepts a candidate factor q and a Mersenne exponent p, and computes 2^p mod q by left-to-right square-and-double. Each modular reduction is issued to the existing `divider` over its start/finished handshake; this block is the master end of that interface. It reports whether q divides 2^p − 1.

## Interface

Parameters:
- `EXP_W`, 32: width of exponent p.
- `Q_W`, 16: width of candidate q. 2·`Q_W` must equal the divider operand width (32).

Ports:
- `sys_clk` in 1: single clock; all logic on its rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in S_IDLE; the command is accepted on `cmd_valid && cmd_ready`.
- `cmd_exp` in `EXP_W`: exponent p.
- `cmd_q` in `Q_W`: candidate q.
- `res_valid` out 1: result held until `res_ready`.
- `res_ready` in 1: result consumed.
- `res_divides` out 1: 1 when the final residue equals 1, meaning q | 2^p − 1.
- `res_residue` out `Q_W`: 2^p mod q.
- `res_err` out 1: q < 2 (rejected).
- `div_start` out 1: one-cycle request pulse to the divider.
- `div_numerator` out 32: r², registered.
- `div_denominator` out 32: {16'b0, q}, registered.
- `div_remainder` in 32: divider result. Only the low `Q_W` bits are used.
- `div_finished` in 1: divider done flag (pulse or level).

## Operation

- States: S_IDLE, S_SCAN, S_SQ, S_START, S_WAIT, S_DBL, S_DONE.
- **S_IDLE**
  - On accept: latch p into shift register `e`, latch q, set r = 1, set bit counter = `EXP_W`.
  - If q < 2: go to S_DONE with `res_err`=1, residue 0, divides 0.
  - Otherwise go to S_SCAN.
- **S_SCAN**
  - While e[MSB]==0 and counter ≠ 0: shift e left by one and decrement the counter. This consumes one bit per cycle.
  - When counter==0: go to S_DONE. This handles p==0, which gives residue 1 and divides 1.
  - When e[MSB]==1: go to S_SQ.
- **S_SQ**: register `div_numerator` = r·r (Q_W×Q_W → 32-bit, no overflow) and `div_denominator` = q. Go to S_START.
- **S_START**: `div_start`=1 for exactly this cycle. Go to S_WAIT.
- **S_WAIT**
  - `div_start`=0 throughout.
  - `div_finished` is ignored on the first S_WAIT cycle. This guards against a stale level from the previous operation.
  - From the second cycle on, the first high `div_finished` loads r = `div_remainder[Q_W-1:0]` and moves to S_DBL.
- **S_DBL**
  - If e[MSB]==1: t = 2r as a Q_W+1-bit value; r = (t ≥ q) ? t − q : t.
  - Shift e left and decrement the counter.
  - If counter==0, go to S_DONE; otherwise go to S_SQ.
- **S_DONE**
  - `res_valid`=1; outputs are stable.
  - On `res_ready`, go to S_IDLE. Outputs keep their values, but `res_valid` drops.
- Invariant: r < q after every reduction and every double.
- `div_finished` outside S_WAIT has no effect.
- A new command is never accepted while `res_valid` is high.

## Timing

- Reset values: `cmd_ready` 0 during reset and 1 on the first cycle after; `res_valid`, `res_divides`, `res_err` = 0; `res_residue` = 0; `div_start` = 0; `div_numerator` and `div_denominator` = 0; state S_IDLE.
- Reset mid-operation: the next cycle is S_IDLE with no further `div_start`. The divider is reset from the same `sys_rst`.
- Per processed bit: 3 + L cycles, where L ≥ 2 is the number of cycles from `div_start` to the accepted `div_finished`.
- Total latency: 1 (accept) + z (leading zeros) + k·(3 + L) + 1 (S_DONE entry), where k = `EXP_W` − z.
- Back-to-back commands: `cmd_ready` is high on the cycle after `res_valid`/`res_ready` completes.

## Structure

- Package `mersenne_pkg`:
  - state enum `drv_state_t`
  - `EXP_W`/`Q_W` defaults
  - `DIV_W`=32
- Sub-module `mod_double`: combinational (r, q) → (2r ≥ q ? 2r − q : 2r), Q_W wide. Instantiated once for S_DBL.
- Everything else stays in the top FSM. Target size is about 200 lines.

## Test plan

Use a behavioural divider model with random latency of 2–40 cycles; finished is held as a level until the next start.

- p=11, q=23 → residue 1, divides 1 (2047 = 23·89).
- p=11, q=13 → residue 7, divides 0.
- p=23, q=47 → residue 1, divides 1. p=0, q=5 → residue 1, divides 1, zero `div_start` pulses.
- q=0 and q=1 → `res_err` 1, residue 0, no `div_start`. p=5, q=2 → residue 0, divides 0.
- Assert `sys_rst` during S_WAIT of p=23, q=47 → outputs return to reset values next cycle. Then rerun with `div_finished` stuck high across commands → still exactly one `div_start` per S_START and correct result. Hold `res_ready` low for 10 cycles → result held stable and `cmd_ready` stays 0.
